// File: rtl/trn_rx_mwr_decoder.sv
// rtl/trn_rx_mwr_decoder.sv - TRN Rx single-DW memory-write decoder to register-write strobe
// Non-matching or malformed TLPs are consumed and tallied in a saturating drop counter.
module trn_rx_mwr_decoder #(
  parameter int BAR_NUM    = 0,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset_n,
  input  logic                  trn_lnk_up_n,
  input  logic [63:0]           trn_rd,
  input  logic [7:0]            trn_rrem_n,
  input  logic                  trn_rsof_n,
  input  logic                  trn_reof_n,
  input  logic                  trn_rsrc_rdy_n,
  input  logic                  trn_rsrc_dsc_n,
  input  logic [6:0]            trn_rbar_hit_n,
  output logic                  trn_rdst_rdy_n,
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [31:0]           reg_wr_data,
  output logic [3:0]            reg_wr_be,
  output logic [15:0]           drop_count
);

  typedef enum logic [2:0] {IDLE, H3, H4, D4, DROP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            be_q, be_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, wr_addr_nxt;
  logic [31:0]           wr_data_nxt;
  logic [3:0]            wr_be_nxt;
  logic                  wr_nxt, idle_step;
  logic [1:0]            drop_inc;
  logic [16:0]           drop_sum;
  logic                  accept, sof, last, hdr_ok;
  logic                  unused_bar_bits;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign accept = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof    = ~trn_rsof_n;
  assign last   = ~trn_reof_n;
  assign hdr_ok = (trn_rd[60:56] == 5'b00000) && trn_rd[62] &&
                  (trn_rd[41:32] == 10'd1) && !trn_rbar_hit_n[BAR_NUM];
  assign unused_bar_bits = &{1'b0, trn_rbar_hit_n};

  always_comb begin
    state_nxt   = state;
    be_nxt      = be_q;
    addr_nxt    = addr_q;
    wr_nxt      = 1'b0;
    wr_addr_nxt = reg_wr_addr;
    wr_data_nxt = reg_wr_data;
    wr_be_nxt   = reg_wr_be;
    drop_inc    = 2'd0;
    idle_step   = 1'b0;

    if (trn_lnk_up_n) begin
      state_nxt = IDLE;
    end else if (!trn_rsrc_dsc_n) begin
      state_nxt = IDLE;
      if (state != IDLE) drop_inc = 2'd1;
    end else if (accept) begin
      case (state)
        IDLE: idle_step = 1'b1;
        H3: begin
          if (sof) begin
            drop_inc  = 2'd1;
            idle_step = 1'b1;
          end else if (last && trn_rrem_n == 8'h00) begin
            wr_nxt      = 1'b1;
            wr_addr_nxt = trn_rd[ADDR_WIDTH+33:34];
            wr_data_nxt = bswap(trn_rd[31:0]);
            wr_be_nxt   = be_q;
            state_nxt   = IDLE;
          end else begin
            drop_inc  = 2'd1;
            state_nxt = last ? IDLE : DROP;
          end
        end
        H4: begin
          if (sof) begin
            drop_inc  = 2'd1;
            idle_step = 1'b1;
          end else if (!last) begin
            addr_nxt  = trn_rd[ADDR_WIDTH+1:2];
            state_nxt = D4;
          end else begin
            drop_inc  = 2'd1;
            state_nxt = IDLE;
          end
        end
        D4: begin
          if (sof) begin
            drop_inc  = 2'd1;
            idle_step = 1'b1;
          end else if (last && trn_rrem_n == 8'h0F) begin
            wr_nxt      = 1'b1;
            wr_addr_nxt = addr_q;
            wr_data_nxt = bswap(trn_rd[63:32]);
            wr_be_nxt   = be_q;
            state_nxt   = IDLE;
          end else begin
            drop_inc  = 2'd1;
            state_nxt = last ? IDLE : DROP;
          end
        end
        DROP: if (last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase

      // An interrupting SOF is handled exactly like a fresh SOF seen in IDLE.
      if (idle_step) begin
        state_nxt = IDLE;
        if (sof) begin
          if (last) begin
            drop_inc = drop_inc + 2'd1;
          end else if (hdr_ok) begin
            be_nxt    = trn_rd[3:0];
            state_nxt = trn_rd[61] ? H4 : H3;
          end else begin
            drop_inc  = drop_inc + 2'd1;
            state_nxt = DROP;
          end
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + {15'd0, drop_inc};

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state          <= IDLE;
      be_q           <= '0;
      addr_q         <= '0;
      trn_rdst_rdy_n <= 1'b1;
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      reg_wr_be      <= '0;
      drop_count     <= '0;
    end else begin
      state          <= state_nxt;
      be_q           <= be_nxt;
      addr_q         <= addr_nxt;
      trn_rdst_rdy_n <= trn_lnk_up_n;
      reg_wr_en      <= wr_nxt;
      reg_wr_addr    <= wr_addr_nxt;
      reg_wr_data    <= wr_data_nxt;
      reg_wr_be      <= wr_be_nxt;
      drop_count     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_trn_rx_mwr_decoder.sv
// tb/tb_trn_rx_mwr_decoder.sv - self-checking bench for trn_rx_mwr_decoder
// Directed literal checks plus randomized TLP traffic against a per-TLP reference model.
module tb_trn_rx_mwr_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lnk_up_n = 1'b1;
  logic [63:0] rd = '0;
  logic [7:0]  rrem_n = 8'h00;
  logic        rsof_n = 1'b1, reof_n = 1'b1, rsrc_rdy_n = 1'b1, dsc_n = 1'b1;
  logic [6:0]  bar_n = 7'h7F;
  logic        rdst_rdy_n, reg_wr_en;
  logic [9:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_be;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int gmax = 0;

  trn_rx_mwr_decoder #(.BAR_NUM(0), .ADDR_WIDTH(10)) dut (
    .trn_clk(clk), .trn_reset_n(rst_n), .trn_lnk_up_n(lnk_up_n), .trn_rd(rd),
    .trn_rrem_n(rrem_n), .trn_rsof_n(rsof_n), .trn_reof_n(reof_n),
    .trn_rsrc_rdy_n(rsrc_rdy_n), .trn_rsrc_dsc_n(dsc_n), .trn_rbar_hit_n(bar_n),
    .trn_rdst_rdy_n(rdst_rdy_n), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .reg_wr_be(reg_wr_be), .drop_count(drop_count)
  );

  always #2 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: tracks the TLP in flight by beat index rather than by FSM state.
  localparam int NONE = 0, WR = 1, DROPPING = 2;
  int          m_pkt, m_idx, m_drop;
  logic        m_is4, m_rdy_n, m_wr_en;
  logic [3:0]  m_be, m_wr_be;
  logic [9:0]  m_addr, m_wr_addr;
  logic [31:0] m_wr_data;

  function automatic logic [31:0] host_order(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int inc;
    logic first, lastb, qual, final_beat;
    if (!rst_n) begin
      m_pkt = NONE; m_idx = 0; m_drop = 0; m_is4 = 0; m_rdy_n = 1; m_wr_en = 0;
      m_be = 0; m_wr_be = 0; m_addr = 0; m_wr_addr = 0; m_wr_data = 0;
    end else begin
      inc = 0;
      m_wr_en = 0;
      first = !rsof_n;
      lastb = !reof_n;
      qual = (rd[60:56] == 0) && (rd[62:61] == 2'b10 || rd[62:61] == 2'b11) &&
             (rd[41:32] == 1) && !bar_n[0];
      if (lnk_up_n) m_pkt = NONE;
      else if (!dsc_n) begin
        if (m_pkt != NONE) inc++;
        m_pkt = NONE;
      end else if (!rsrc_rdy_n && !m_rdy_n) begin
        if (m_pkt == DROPPING) begin
          if (lastb) m_pkt = NONE;
        end else if (first) begin
          if (m_pkt == WR) inc++;
          if (lastb) begin inc++; m_pkt = NONE; end
          else if (qual) begin m_pkt = WR; m_idx = 0; m_is4 = rd[61]; m_be = rd[3:0]; end
          else begin inc++; m_pkt = DROPPING; end
        end else if (m_pkt == WR) begin
          m_idx++;
          final_beat = m_is4 ? (m_idx == 2) : (m_idx == 1);
          if (!final_beat) begin
            if (lastb) begin inc++; m_pkt = NONE; end
            else m_addr = 10'((rd[31:0] >> 2) & 32'h3FF);
          end else if (lastb && rrem_n == (m_is4 ? 8'h0F : 8'h00)) begin
            m_wr_en = 1;
            m_wr_addr = m_is4 ? m_addr : 10'((rd[63:32] >> 2) & 32'h3FF);
            m_wr_data = host_order(m_is4 ? rd[63:32] : rd[31:0]);
            m_wr_be = m_be;
            m_pkt = NONE;
          end else begin
            inc++;
            m_pkt = lastb ? NONE : DROPPING;
          end
        end
      end
      m_drop = (m_drop + inc > 65535) ? 65535 : m_drop + inc;
      m_rdy_n = lnk_up_n;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdst_rdy_n", 64'(rdst_rdy_n), 64'(m_rdy_n));
      chk("reg_wr_en", 64'(reg_wr_en), 64'(m_wr_en));
      chk("reg_wr_addr", 64'(reg_wr_addr), 64'(m_wr_addr));
      chk("reg_wr_data", 64'(reg_wr_data), 64'(m_wr_data));
      chk("reg_wr_be", 64'(reg_wr_be), 64'(m_wr_be));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (reg_wr_en) wr_cnt++;
    end
  end

  function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [4:0] typ,
                                      input logic [9:0] len, input logic [3:0] be);
    logic [31:0] dw0;
    dw0 = '0;
    dw0[30:29] = fmt;
    dw0[28:24] = typ;
    dw0[9:0] = len;
    return {dw0, 16'h0100, 8'($urandom), 4'h0, be};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [7:0] rrem,
                           input logic [63:0] d, input logic [6:0] bar, input int pre);
    rsrc_rdy_n = 1; rsof_n = 1; reof_n = 1;
    tick(pre);
    rsrc_rdy_n = 0; rsof_n = !s; reof_n = !e; rrem_n = rrem; rd = d; bar_n = bar;
    tick(1);
    rsrc_rdy_n = 1; rsof_n = 1; reof_n = 1;
  endtask

  function automatic int pg();
    return int'($urandom_range(0, gmax));
  endfunction

  task automatic mwr3(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [6:0] bar);
    send_beat(1, 0, 8'h00, hdr(2'b10, 5'd0, 10'd1, be), bar, pg());
    send_beat(0, 1, 8'h00, {a, d}, bar, pg());
  endtask

  task automatic mwr4(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [6:0] bar);
    send_beat(1, 0, 8'h00, hdr(2'b11, 5'd0, 10'd1, be), bar, pg());
    send_beat(0, 0, 8'h00, {32'h0, a}, bar, pg());
    send_beat(0, 1, 8'h0F, {d, 32'h0}, bar, pg());
  endtask

  task automatic mrd(input logic [31:0] a);
    send_beat(1, 0, 8'h00, hdr(2'b00, 5'd0, 10'd1, 4'hF), 7'h7E, pg());
    send_beat(0, 1, 8'h0F, {a, 32'h0}, 7'h7E, pg());
  endtask

  task automatic mwr3_len2(input logic [31:0] a);
    send_beat(1, 0, 8'h00, hdr(2'b10, 5'd0, 10'd2, 4'hF), 7'h7E, pg());
    send_beat(0, 0, 8'h00, {a, $urandom}, 7'h7E, pg());
    send_beat(0, 1, 8'h0F, {$urandom, 32'h0}, 7'h7E, pg());
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(2);
    rst_n = 1;
    tick(2);
  endtask

  initial begin : stim
    int k, w0;
    logic [6:0] hit;
    tick(2);
    rst_n = 1;
    chk("reset_rdst", 64'(rdst_rdy_n), 64'h1);
    chk("reset_wr_en", 64'(reg_wr_en), 64'h0);
    chk("reset_drop", 64'(drop_count), 64'h0);
    chk("reset_data", 64'(reg_wr_data), 64'h0);
    lnk_up_n = 0;
    tick(1);
    chk("link_up_rdst", 64'(rdst_rdy_n), 64'h0);
    tick(1);

    mwr3(32'h0000_0010, 32'h1122_3344, 4'hF, 7'h7E);
    chk("t1_wr_en", 64'(reg_wr_en), 64'h1);
    chk("t1_addr", 64'(reg_wr_addr), 64'h4);
    chk("t1_data", 64'(reg_wr_data), 64'h4433_2211);
    chk("t1_be", 64'(reg_wr_be), 64'hF);
    chk("t1_drop", 64'(drop_count), 64'h0);
    tick(1);
    chk("t1_pulse_end", 64'(reg_wr_en), 64'h0);
    chk("t1_hold_data", 64'(reg_wr_data), 64'h4433_2211);

    mwr4(32'h0000_0FFC, 32'hAABB_CCDD, 4'h3, 7'h7E);
    chk("t2_wr_en", 64'(reg_wr_en), 64'h1);
    chk("t2_addr", 64'(reg_wr_addr), 64'h3FF);
    chk("t2_data", 64'(reg_wr_data), 64'hDDCC_BBAA);
    chk("t2_be", 64'(reg_wr_be), 64'h3);

    do_reset();
    w0 = wr_cnt;
    mrd(32'h0000_0100);
    mwr3_len2(32'h0000_0200);
    mwr3(32'h0000_0300, 32'h5555_AAAA, 4'hF, 7'h7F);
    tick(2);
    chk("t3_no_write", 64'(wr_cnt - w0), 64'h0);
    chk("t3_drop", 64'(drop_count), 64'h3);
    chk("t3_model_drop", 64'(m_drop), 64'h3);

    w0 = wr_cnt;
    send_beat(1, 0, 8'h00, hdr(2'b10, 5'd0, 10'd1, 4'h9), 7'h7E, 0);
    send_beat(0, 1, 8'h00, {32'h0000_0020, 32'h0102_0304}, 7'h7E, 4);
    chk("t4_wr_en", 64'(reg_wr_en), 64'h1);
    chk("t4_data", 64'(reg_wr_data), 64'h0403_0201);
    chk("t4_addr", 64'(reg_wr_addr), 64'h8);
    chk("t4_be", 64'(reg_wr_be), 64'h9);
    tick(3);
    chk("t4_one_strobe", 64'(wr_cnt - w0), 64'h1);

    do_reset();
    w0 = wr_cnt;
    send_beat(1, 0, 8'h00, hdr(2'b11, 5'd0, 10'd1, 4'hF), 7'h7E, 0);
    dsc_n = 0;
    tick(1);
    dsc_n = 1;
    mwr3(32'h0000_0044, 32'hDEAD_BEEF, 4'hC, 7'h7E);
    tick(2);
    chk("t5_one_strobe", 64'(wr_cnt - w0), 64'h1);
    chk("t5_addr", 64'(reg_wr_addr), 64'h11);
    chk("t5_data", 64'(reg_wr_data), 64'hEFBE_ADDE);
    chk("t5_drop", 64'(drop_count), 64'h1);

    // Randomized traffic, including malformed frames, discontinues and link drops.
    do_reset();
    gmax = 2;
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 11));
      hit = 7'($urandom) & 7'h7E;
      case (k)
        0, 1, 2: mwr3($urandom, $urandom, 4'($urandom), hit);
        3, 4: mwr4($urandom, $urandom, 4'($urandom), hit);
        5: mrd($urandom);
        6: mwr3_len2($urandom);
        7: mwr3($urandom, $urandom, 4'hF, hit | 7'h01);
        8: begin
          send_beat(1, 0, 8'h00, hdr(2'b10, 5'd0, 10'd1, 4'hF), hit, pg());
          send_beat(0, 1, 8'h0F, {$urandom, $urandom}, hit, pg());
        end
        9: begin
          send_beat(1, 0, 8'h00, hdr(2'b11, 5'd0, 10'd1, 4'hF), hit, pg());
          send_beat(0, $urandom_range(0, 1) == 1, 8'h00, {$urandom, $urandom}, hit, pg());
          if ($urandom_range(0, 1) == 1) send_beat(0, 0, 8'h0F, {$urandom, $urandom}, hit, pg());
        end
        10: begin
          send_beat(1, 0, 8'h00, hdr(2'b10, 5'd0, 10'd1, 4'hF), hit, pg());
          if ($urandom_range(0, 1) == 1) begin
            dsc_n = 0; rsrc_rdy_n = 1'($urandom);
            tick(1);
            dsc_n = 1; rsrc_rdy_n = 1;
          end else begin
            send_beat(0, 0, 8'h00, {$urandom, $urandom}, hit, pg());
            send_beat(0, 1, 8'h0F, {$urandom, $urandom}, hit, pg());
          end
        end
        default: begin
          send_beat(1, 0, 8'h00, hdr(2'b11, 5'd0, 10'd1, 4'hF), hit, pg());
          lnk_up_n = 1;
          tick(int'($urandom_range(1, 3)));
          lnk_up_n = 0;
          tick(2);
        end
      endcase
    end
    gmax = 0;
    tick(3);

    do_reset();
    rd = hdr(2'b00, 5'd0, 10'd1, 4'hF);
    bar_n = 7'h7E; rsof_n = 0; reof_n = 0; rsrc_rdy_n = 0;
    tick(65535);
    rsof_n = 1; reof_n = 1; rsrc_rdy_n = 1;
    chk("sat_reach", 64'(drop_count), 64'hFFFF);
    mrd(32'h0000_0008);
    tick(1);
    chk("sat_hold", 64'(drop_count), 64'hFFFF);

    mwr3(32'h0000_0040, 32'hCAFE_F00D, 4'h5, 7'h7E);
    send_beat(1, 0, 8'h00, hdr(2'b11, 5'd0, 10'd1, 4'hF), 7'h7E, 0);
    rst_n = 0;
    #1;
    chk("rst_wr_en", 64'(reg_wr_en), 64'h0);
    chk("rst_addr", 64'(reg_wr_addr), 64'h0);
    chk("rst_data", 64'(reg_wr_data), 64'h0);
    chk("rst_be", 64'(reg_wr_be), 64'h0);
    chk("rst_drop", 64'(drop_count), 64'h0);
    chk("rst_rdst", 64'(rdst_rdy_n), 64'h1);
    tick(2);
    rst_n = 1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trn_rx_mwr_decoder.md
Name: trn_rx_mwr_decoder

Overview:
Receive-side TLP parser on the endpoint's 64-bit TRN Rx local-link, in the trn_clk domain.
Accepts single-DW Memory Write TLPs (3DW or 4DW header) that hit a selected BAR and turns each one into a one-cycle register-write strobe with address, data and byte enables.
All other TLPs are consumed and discarded, and a saturating counter records them.
It is the host-to-card control path that pairs with the DMA engine's TLP transmitter.

Parameters:
BAR_NUM, 0, index into trn_rbar_hit_n[6:0] that qualifies a write.
ADDR_WIDTH, 10, width of the DW register address (taken from TLP address bits [ADDR_WIDTH+1:2]).

Ports:
trn_clk  input  1  endpoint user clock (250 MHz); all logic is on its rising edge.
trn_reset_n  input  1  asynchronous, active-low reset.
trn_lnk_up_n  input  1  link up, active-low.
trn_rd  input  64  Rx data; DW0 is in [63:32].
trn_rrem_n  input  8  Rx remainder; 8'h00 means 2 DWs valid, 8'h0F means 1 DW valid.
trn_rsof_n  input  1  start of frame, active-low.
trn_reof_n  input  1  end of frame, active-low.
trn_rsrc_rdy_n  input  1  source ready, active-low.
trn_rsrc_dsc_n  input  1  source discontinue, active-low.
trn_rbar_hit_n  input  7  BAR hit, active-low; valid on the SOF beat.
trn_rdst_rdy_n  output  1  destination ready, active-low.
reg_wr_en  output  1  one-cycle write strobe.
reg_wr_addr  output  ADDR_WIDTH  DW address.
reg_wr_data  output  32  write data in host byte order.
reg_wr_be  output  4  byte enables; bit i qualifies reg_wr_data[8i+7:8i].
drop_count  output  16  saturating count of discarded TLPs.

Behaviour:
- Reset (trn_reset_n low, asynchronous):
  - state = IDLE.
  - reg_wr_en = 0, reg_wr_addr = 0, reg_wr_data = 0, reg_wr_be = 0, drop_count = 0.
  - trn_rdst_rdy_n = 1.
- Ready:
  - trn_rdst_rdy_n is registered and equals trn_lnk_up_n: 0 when the link is up, 1 when it is down.
  - A beat is accepted when trn_rsrc_rdy_n == 0 and trn_rdst_rdy_n == 0.
- Header fields on the SOF beat:
  - fmt = rd[62:61], type = rd[60:56], length = rd[41:32].
  - first_be = rd[3:0].
- Qualify on the SOF beat. All of the following must hold:
  - type == 5'b00000;
  - fmt == 2'b10 (3DW) or 2'b11 (4DW);
  - length == 10'd1;
  - trn_rbar_hit_n[BAR_NUM] == 0.
- States:
  - IDLE: on an accepted SOF beat that qualifies, latch be and go to H3 (fmt 10) or H4 (fmt 11). Otherwise go to DROP.
  - H3: the next accepted beat must have eof = 0 and rrem_n = 8'h00.
    - addr = rd[ADDR_WIDTH+33:34] (DW2 = rd[63:32]).
    - data = rd[31:0].
    - Emit the write, then go to IDLE.
  - H4: the next accepted beat has eof = 1. Latch addr = rd[ADDR_WIDTH+1:2] (DW3 = rd[31:0]) and go to D4.
  - D4: the next accepted beat must have eof = 0 and rrem_n = 8'h0F.
    - data = rd[63:32].
    - Emit the write, then go to IDLE.
  - DROP: consume beats until an accepted EOF beat, then go to IDLE.
- Drop accounting: drop_count increments by 1 when a TLP ends without a write, saturating at 16'hFFFF. It increments in exactly these cases:
  - entering DROP from IDLE;
  - a beat in H3/H4/D4 that violates the eof/rrem rule (including SOF and EOF on the same beat in IDLE);
  - rsrc_dsc_n == 0 while in any non-IDLE state.
- Violation handling:
  - An H3/D4 mismatch with eof = 1 goes to DROP.
  - An H3/D4 mismatch with eof = 0 goes to IDLE.
  - An H4 beat with eof = 0 goes to IDLE.
- Discontinue (rsrc_dsc_n == 0) forces IDLE with no write, regardless of rsrc_rdy_n.
- SOF on a beat accepted in H3/H4/D4: count the current TLP as dropped, then process the beat as IDLE would.
- Write output:
  - reg_wr_en pulses for exactly one cycle, in the cycle after the final beat is accepted.
  - reg_wr_data = {d[7:0], d[15:8], d[23:16], d[31:24]}, where d is the TRN data DW.
  - reg_wr_be = first_be, unswapped.
  - reg_wr_addr, reg_wr_data and reg_wr_be hold their values until the next write.
- Write with first_be == 0: the strobe still fires, with be = 0.
- Link down: while trn_lnk_up_n == 1 the state is forced to IDLE, with no strobe and no count.
- Back-to-back: a new SOF may be accepted in the cycle immediately after an EOF, giving a sustained rate of 1 write per 2 (3DW) or 3 (4DW) cycles.

Test Plan:
- 3DW MWr, BAR0 hit, addr 0x0000_0010, data DW 0x11223344, first_be 0xF -> one cycle after EOF: reg_wr_en = 1, reg_wr_addr = 4, reg_wr_data = 0x44332211, reg_wr_be = 4'hF; drop_count = 0.
- 4DW MWr, addr_lo 0x0000_0FFC, data 0xAABBCCDD, first_be 0x3 -> reg_wr_addr = 10'h3FF, reg_wr_data = 0xDDCCBBAA, reg_wr_be = 4'h3.
- MRd (type 00000, fmt 00), then an MWr with length 2, then an MWr with trn_rbar_hit_n = 7'h7F -> no reg_wr_en; drop_count = 3.
- 3DW MWr with rsrc_rdy_n deasserted for 4 cycles between beats -> exactly one strobe, 1 cycle after the second beat; data is correct.
- rsrc_dsc_n pulsed in H4 of a 4DW MWr, followed by a valid 3DW MWr -> only the 3DW write strobes; drop_count = 1.
- drop_count preset to 0xFFFF by sending 65535 MRd TLPs, then one more MRd -> drop_count stays 0xFFFF. Assert trn_reset_n mid-TLP -> all outputs return to 0 immediately.
